afe_adc_multi_reader: RTL and testbench
=======================================

Name: afe_adc_multi_reader

Overview:
- Parametrised successor to the AFE result-readout block.
- After each ADC_RDY it reads NUM_CH consecutive AFE result registers over the shared byte-level SPI engine. Each register takes one address byte followed by BYTES data bytes, MSB first.
- All channels are committed atomically, with a valid strobe, overrun detection and clean abort on brightness-adjust or diagnostic mode.
- Sits between the AFE control FSM and the SPI byte engine; feeds the downstream PPG filter.

Parameters:
- NUM_CH, 2, number of consecutive result registers per frame (1..8).
- BYTES, 3, data bytes per register (1..4); DW = 8*BYTES.
- START_ADDR, 8'h2E, register address of channel 0; channel k reads START_ADDR+k (8-bit wrap).

Ports:
- div_clk  in  1  block clock.
- rst  in  1  reset.
- adc_rdy  in  1  AFE conversion-ready, synchronised, level; rising edge starts a frame.
- brt_adj_en  in  1  brightness adjust active; suspends block.
- diag_en  in  1  diagnostics active; suspends block.
- spi_rx_data  in  8  byte returned by SPI engine, valid with spi_done.
- spi_done  in  1  one-cycle pulse, current byte transfer complete.
- spi_wr_en  out  1  request address-byte write; held until spi_done.
- spi_rd_en  out  1  request data-byte read; held until spi_done.
- spi_tx_data  out  8  address byte for current channel.
- ch_data  out  NUM_CH*DW  committed results; channel k at [k*DW +: DW].
- data_valid  out  1  one-cycle pulse when ch_data updated.
- busy  out  1  frame in progress.
- overrun  out  1  sticky; set on adc_rdy edge while busy; cleared by rst only.

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is div_clk. Reset values: spi_wr_en=0, spi_rd_en=0, spi_tx_data=START_ADDR, ch_data=0, data_valid=0, busy=0, overrun=0, FSM=IDLE, ch=0, byte_cnt=0.
- suspend = brt_adj_en | diag_en.
- rdy_rise = adc_rdy & ~adc_rdy_d; adc_rdy_d is a register reset to 0.
- FSM states: IDLE, ADDR, DATA, NEXT, COMMIT.
- IDLE: on rdy_rise & ~suspend -> ADDR with ch=0 and spi_tx_data=START_ADDR.
- ADDR:
  - spi_wr_en=1, spi_rd_en=0.
  - On spi_done: spi_wr_en=0 next cycle, byte_cnt=0 -> DATA.
- DATA:
  - spi_rd_en=1; spi_rd_en drops for exactly the cycle after each spi_done, then re-asserts.
  - On spi_done: shadow[ch][DW-1-8*byte_cnt -: 8] <= spi_rx_data.
  - If byte_cnt==BYTES-1 -> NEXT, else byte_cnt+1.
- NEXT:
  - If ch==NUM_CH-1 -> COMMIT.
  - Else ch+1, spi_tx_data+1 (mod 256) -> ADDR.
  - One idle cycle.
- COMMIT: ch_data<=shadow (all channels in the same cycle), data_valid=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE.
- Never assert spi_wr_en and spi_rd_en together.
- A spi_done outside ADDR/DATA is ignored.
- rdy_rise while busy (and not suspended):
  - overrun<=1.
  - Abort the current frame: shadow is discarded, ch_data is unchanged, no data_valid.
  - Restart at ADDR with ch=0 on the next cycle.
- suspend asserted in any state:
  - Next edge: FSM=IDLE, spi_wr_en=spi_rd_en=0, ch=byte_cnt=0, spi_tx_data=START_ADDR.
  - ch_data holds its value; no data_valid.
  - rdy_rise while suspended is ignored and does not set overrun.
- Leaving suspend while adc_rdy is held high does not start a frame; a new rising edge is required.
- Frame latency, from rdy_rise edge to data_valid, with SPI engine latency L cycles per byte: NUM_CH*((BYTES+1)*(L+1)+1)+1 cycles.

Decomposition:
- Shared package afe_pkg holds:
  - FSM state enum (IDLE, ADDR, DATA, NEXT, COMMIT).
  - AFE register address constants: LED2VAL=8'h2A, ALED2VAL=8'h2B, LED1VAL=8'h2C, ALED1VAL=8'h2D, LED2_SUB=8'h2E, LED1_SUB=8'h2F.
- No sub-module needed; the shadow/commit register bank may optionally be split out as afe_result_bank (NUM_CH, DW).

Test Plan:
- Basic frame: NUM_CH=2, BYTES=3, SPI model L=4. Rx bytes 12,34,56 then AB,CD,EF -> tx addresses 2E then 2F; ch_data[23:0]=0x123456, ch_data[47:24]=0xABCDEF; single data_valid; busy drops the same cycle.
- Handshake check: monitor spi_wr_en/spi_rd_en -> never both high; exactly 2 write and 6 read transactions; each request low for exactly 1 cycle after each spi_done.
- Overrun: second adc_rdy rising edge during channel 1 byte 2 -> overrun=1; ch_data keeps previous frame; restart at address 2E; next valid frame commits new data.
- Suspend mid-frame: assert diag_en during DATA of channel 0 -> next cycle requests=0, busy=0, ch_data unchanged, no data_valid. adc_rdy edge while diag_en=1 is ignored.
- Parameter sweep: NUM_CH=4, BYTES=2, START_ADDR=8'hFE -> addresses FE, FF, 00, 01 (wrap); each 16-bit word MSB first.
- Reset mid-frame: rst asserted in DATA -> all outputs return to reset values asynchronously, including overrun=0.

Source files
------------

// File: rtl/afe_pkg.sv
// ---------------------------------------------------------------------------
// afe_pkg
// Declarations shared by the AFE readout blocks.
//   - afe_state_e : frame sequencer states of the multi-channel result reader
//   - AFE result register addresses (LED / ambient values and the
//     ambient-subtracted results that the PPG path normally reads)
// ---------------------------------------------------------------------------
package afe_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DATA   = 3'd2,
        NEXT   = 3'd3,
        COMMIT = 3'd4
    } afe_state_e;

    localparam logic [7:0] LED2VAL  = 8'h2A;
    localparam logic [7:0] ALED2VAL = 8'h2B;
    localparam logic [7:0] LED1VAL  = 8'h2C;
    localparam logic [7:0] ALED1VAL = 8'h2D;
    localparam logic [7:0] LED2_SUB = 8'h2E;
    localparam logic [7:0] LED1_SUB = 8'h2F;

endpackage : afe_pkg

// File: rtl/afe_adc_multi_reader.sv
// ---------------------------------------------------------------------------
// afe_adc_multi_reader
// On every rising edge of adc_rdy, reads NUM_CH consecutive AFE result
// registers (START_ADDR, START_ADDR+1, ...) through the byte-level SPI engine.
// Each register costs one address-byte write followed by BYTES data-byte
// reads, MSB first. Results are collected in a shadow bank and committed to
// ch_data in one cycle together with a data_valid pulse.
//
// Ports
//   div_clk, rst     : block clock, asynchronous active-high reset
//   adc_rdy          : conversion ready (synchronised level)
//   brt_adj_en       : brightness adjust active -> block suspended
//   diag_en          : diagnostics active       -> block suspended
//   spi_rx_data      : byte returned by SPI engine, valid with spi_done
//   spi_done         : one-cycle pulse, byte transfer complete
//   spi_wr_en        : address-byte write request, held until spi_done
//   spi_rd_en        : data-byte read request, held until spi_done
//   spi_tx_data      : address byte of the current channel
//   ch_data          : committed results, channel k at [k*DW +: DW]
//   data_valid       : one-cycle pulse when ch_data is updated
//   busy             : frame in progress
//   overrun          : sticky, new adc_rdy edge arrived during a frame
// ---------------------------------------------------------------------------
module afe_adc_multi_reader
    import afe_pkg::*;
#(
    parameter int         NUM_CH     = 2,
    parameter int         BYTES      = 3,
    parameter logic [7:0] START_ADDR = 8'h2E
) (
    input  logic                     div_clk,
    input  logic                     rst,
    input  logic                     adc_rdy,
    input  logic                     brt_adj_en,
    input  logic                     diag_en,
    input  logic [7:0]               spi_rx_data,
    input  logic                     spi_done,
    output logic                     spi_wr_en,
    output logic                     spi_rd_en,
    output logic [7:0]               spi_tx_data,
    output logic [NUM_CH*8*BYTES-1:0] ch_data,
    output logic                     data_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int DW   = 8 * BYTES;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BC_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

    afe_state_e               state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [BC_W-1:0]          byte_cnt_q, byte_cnt_d;
    logic                     spi_wr_en_q, spi_wr_en_d;
    logic                     spi_rd_en_q, spi_rd_en_d;
    logic [7:0]               spi_tx_data_q, spi_tx_data_d;
    logic [NUM_CH*DW-1:0]     ch_data_q, ch_data_d;
    logic [NUM_CH*DW-1:0]     shadow_q, shadow_d;
    logic                     data_valid_q, data_valid_d;
    logic                     busy_q, busy_d;
    logic                     overrun_q, overrun_d;
    logic                     adc_rdy_prev_q, adc_rdy_prev_d;

    logic suspend;
    logic rdy_rise;
    logic restart;
    logic wr_done;
    logic rd_done;

    always_comb begin
        suspend  = brt_adj_en | diag_en;
        rdy_rise = adc_rdy & ~adc_rdy_prev_q;
        restart  = rdy_rise & ~suspend & (state_q != IDLE);
        // A done only counts while our own request is up, so a transfer
        // left over from an aborted frame cannot be mistaken for a new one.
        wr_done  = spi_done & spi_wr_en_q & (state_q == ADDR);
        rd_done  = spi_done & spi_rd_en_q & (state_q == DATA);
    end

    // Next-state and output computation. Requests are derived from the
    // current state, so they rise one cycle after a state is entered and
    // fall in the cycle after each accepted spi_done.
    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        byte_cnt_d     = byte_cnt_q;
        spi_tx_data_d  = spi_tx_data_q;
        shadow_d       = shadow_q;
        ch_data_d      = ch_data_q;
        data_valid_d   = 1'b0;
        overrun_d      = overrun_q;
        spi_wr_en_d    = 1'b0;
        spi_rd_en_d    = 1'b0;
        adc_rdy_prev_d = adc_rdy;

        if (suspend) begin
            state_d       = IDLE;
            ch_d          = '0;
            byte_cnt_d    = '0;
            spi_tx_data_d = START_ADDR;
        end else if (restart) begin
            // Abort: requests drop for one cycle, shadow contents are
            // simply overwritten by the restarted frame.
            overrun_d     = 1'b1;
            state_d       = ADDR;
            ch_d          = '0;
            byte_cnt_d    = '0;
            spi_tx_data_d = START_ADDR;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rdy_rise) begin
                        state_d       = ADDR;
                        ch_d          = '0;
                        byte_cnt_d    = '0;
                        spi_tx_data_d = START_ADDR;
                    end
                end
                ADDR: begin
                    spi_wr_en_d = ~wr_done;
                    if (wr_done) begin
                        byte_cnt_d = '0;
                        state_d    = DATA;
                    end
                end
                DATA: begin
                    spi_rd_en_d = ~rd_done;
                    if (rd_done) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            for (int b = 0; b < BYTES; b++) begin
                                if (ch_q == CH_W'(c) && byte_cnt_q == BC_W'(b)) begin
                                    shadow_d[c*DW + DW - 1 - 8*b -: 8] = spi_rx_data;
                                end
                            end
                        end
                        if (byte_cnt_q == LAST_BYTE) begin
                            state_d = NEXT;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BC_W'(1);
                        end
                    end
                end
                NEXT: begin
                    if (ch_q == LAST_CH) begin
                        state_d = COMMIT;
                    end else begin
                        ch_d          = ch_q + CH_W'(1);
                        spi_tx_data_d = spi_tx_data_q + 8'd1;
                        state_d       = ADDR;
                    end
                end
                COMMIT: begin
                    ch_data_d    = shadow_q;
                    data_valid_d = 1'b1;
                    state_d      = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ch_q           <= '0;
            byte_cnt_q     <= '0;
            spi_wr_en_q    <= 1'b0;
            spi_rd_en_q    <= 1'b0;
            spi_tx_data_q  <= START_ADDR;
            ch_data_q      <= '0;
            data_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            adc_rdy_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            byte_cnt_q     <= byte_cnt_d;
            spi_wr_en_q    <= spi_wr_en_d;
            spi_rd_en_q    <= spi_rd_en_d;
            spi_tx_data_q  <= spi_tx_data_d;
            ch_data_q      <= ch_data_d;
            data_valid_q   <= data_valid_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            adc_rdy_prev_q <= adc_rdy_prev_d;
        end
    end

    // Shadow bank is pure data: it is always fully rewritten before commit.
    always_ff @(posedge div_clk) begin
        shadow_q <= shadow_d;
    end

    assign spi_wr_en   = spi_wr_en_q;
    assign spi_rd_en   = spi_rd_en_q;
    assign spi_tx_data = spi_tx_data_q;
    assign ch_data     = ch_data_q;
    assign data_valid  = data_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule : afe_adc_multi_reader

// File: tb/tb_afe_adc_multi_reader.sv
// ---------------------------------------------------------------------------
// tb_afe_adc_multi_reader
// Directed bench for afe_adc_multi_reader. Instance a uses the default
// parameters (2 channels x 3 bytes from 0x2E), instance b uses 4 channels x
// 2 bytes from 0xFE. A byte-engine responder inside step() answers every
// request with spi_done in the L-th cycle the request is high.
// ---------------------------------------------------------------------------
module tb_afe_adc_multi_reader;

    localparam int L = 4;

    logic div_clk;
    logic rst;

    logic        a_adc_rdy, a_brt, a_diag, a_done, a_wr, a_rd, a_dv, a_busy, a_ovr;
    logic [7:0]  a_rx, a_tx;
    logic [47:0] a_chd;

    logic        b_adc_rdy, b_brt, b_diag, b_done, b_wr, b_rd, b_dv, b_busy, b_ovr;
    logic [7:0]  b_rx, b_tx;
    logic [63:0] b_chd;

    int checks = 0;
    int errors = 0;

    // responder / monitor state
    int         a_cnt, a_nwr, a_nrd, a_both, a_dvn, a_gap, a_gap1, a_gapx;
    bit         a_gap_on;
    logic [7:0] a_rxq[$];
    logic [7:0] a_alog[$];
    int         b_cnt, b_nwr, b_nrd, b_both;
    logic [7:0] b_rxq[$];
    logic [7:0] b_alog[$];

    int lat;
    bit ok;

    afe_adc_multi_reader u_dut_a (
        .div_clk     (div_clk),
        .rst         (rst),
        .adc_rdy     (a_adc_rdy),
        .brt_adj_en  (a_brt),
        .diag_en     (a_diag),
        .spi_rx_data (a_rx),
        .spi_done    (a_done),
        .spi_wr_en   (a_wr),
        .spi_rd_en   (a_rd),
        .spi_tx_data (a_tx),
        .ch_data     (a_chd),
        .data_valid  (a_dv),
        .busy        (a_busy),
        .overrun     (a_ovr)
    );

    afe_adc_multi_reader #(
        .NUM_CH     (4),
        .BYTES      (2),
        .START_ADDR (8'hFE)
    ) u_dut_b (
        .div_clk     (div_clk),
        .rst         (rst),
        .adc_rdy     (b_adc_rdy),
        .brt_adj_en  (b_brt),
        .diag_en     (b_diag),
        .spi_rx_data (b_rx),
        .spi_done    (b_done),
        .spi_wr_en   (b_wr),
        .spi_rd_en   (b_rd),
        .spi_tx_data (b_tx),
        .ch_data     (b_chd),
        .data_valid  (b_dv),
        .busy        (b_busy),
        .overrun     (b_ovr)
    );

    initial div_clk = 1'b0;
    always #5 div_clk = ~div_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        a_nwr = 0; a_nrd = 0; a_dvn = 0; a_gap1 = 0; a_gapx = 0; a_gap_on = 0; a_gap = 0;
        a_alog.delete();
        b_nwr = 0; b_nrd = 0;
        b_alog.delete();
    endtask

    // One clock: wait for the edge, then sample outputs and drive the
    // responders 1 time unit later.
    task automatic step();
        @(posedge div_clk);
        #1;
        // instance a monitor
        if (a_wr === 1'b1 && a_rd === 1'b1) a_both++;
        if (a_dv === 1'b1) a_dvn++;
        if (a_done) begin
            a_done = 1'b0; a_cnt = 0; a_gap_on = 1'b1; a_gap = 0;
        end
        if (a_gap_on) begin
            if (a_wr || a_rd) begin
                if (a_gap == 1) a_gap1++; else a_gapx++;
                a_gap_on = 1'b0;
            end else begin
                a_gap++;
            end
        end
        // instance a responder
        if (a_wr || a_rd) begin
            a_cnt++;
            if (a_cnt == L) begin
                a_done = 1'b1;
                if (a_wr) begin
                    a_alog.push_back(a_tx); a_nwr++;
                end else begin
                    a_rx = (a_rxq.size() > 0) ? a_rxq.pop_front() : 8'h00; a_nrd++;
                end
            end
        end else begin
            a_cnt = 0;
        end
        // instance b monitor + responder
        if (b_wr === 1'b1 && b_rd === 1'b1) b_both++;
        if (b_done) begin
            b_done = 1'b0; b_cnt = 0;
        end
        if (b_wr || b_rd) begin
            b_cnt++;
            if (b_cnt == L) begin
                b_done = 1'b1;
                if (b_wr) begin
                    b_alog.push_back(b_tx); b_nwr++;
                end else begin
                    b_rx = (b_rxq.size() > 0) ? b_rxq.pop_front() : 8'h00; b_nrd++;
                end
            end
        end else begin
            b_cnt = 0;
        end
    endtask

    // Steps until data_valid; lat = cycles between the sampling edge of the
    // stimulus applied just before the call and the data_valid edge.
    task automatic wait_valid(input bit sel, input int budget, output int l);
        l = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if ((sel ? b_dv : a_dv) === 1'b1) begin
                l = i - 1;
                break;
            end
        end
    endtask

    task automatic wait_nrd(input int n, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (a_nrd >= n) begin
                got = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        a_adc_rdy = 0; a_brt = 0; a_diag = 0; a_done = 0; a_rx = 8'h00;
        b_adc_rdy = 0; b_brt = 0; b_diag = 0; b_done = 0; b_rx = 8'h00;
        a_cnt = 0; b_cnt = 0; a_both = 0; b_both = 0;
        clear_stats();
        #2;
        // reset state
        check("rst_wr", a_wr, 0);
        check("rst_rd", a_rd, 0);
        check("rst_tx", a_tx, 8'h2E);
        check("rst_chd", a_chd, 0);
        check("rst_dv", a_dv, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ovr", a_ovr, 0);
        check("rst_tx_b", b_tx, 8'hFE);
        step();
        rst = 1'b0;
        step();

        // basic frame
        clear_stats();
        a_rxq = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        a_adc_rdy = 1'b1;
        wait_valid(1'b0, 200, lat);
        check("basic_latency", lat, 43);
        check("basic_chd", a_chd, 48'hABCDEF_123456);
        check("basic_busy_at_dv", a_busy, 0);
        check("basic_nwr", a_nwr, 2);
        check("basic_nrd", a_nrd, 6);
        check("basic_addr_cnt", a_alog.size(), 2);
        if (a_alog.size() == 2) begin
            check("basic_addr0", a_alog[0], 8'h2E);
            check("basic_addr1", a_alog[1], 8'h2F);
        end
        check("basic_gap1", a_gap1, 6);
        check("basic_gap2", a_gapx, 1);
        step();
        check("basic_dv_pulse", a_dv, 0);
        check("basic_dv_count", a_dvn, 1);
        check("basic_ovr", a_ovr, 0);

        // parameter sweep on instance b: 4 x 16-bit, address wrap
        b_rxq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
        b_adc_rdy = 1'b1;
        wait_valid(1'b1, 300, lat);
        check("sweep_latency", lat, 65);
        check("sweep_chd", b_chd, 64'h0718_E5F6_C3D4_A1B2);
        check("sweep_addr_cnt", b_alog.size(), 4);
        if (b_alog.size() == 4) begin
            check("sweep_addr0", b_alog[0], 8'hFE);
            check("sweep_addr1", b_alog[1], 8'hFF);
            check("sweep_addr2", b_alog[2], 8'h00);
            check("sweep_addr3", b_alog[3], 8'h01);
        end
        check("sweep_nrd", b_nrd, 8);
        check("sweep_busy", b_busy, 0);

        // suspend mid-frame
        a_adc_rdy = 1'b0;
        step();
        clear_stats();
        a_rxq = '{8'h77, 8'h88, 8'h99};
        a_adc_rdy = 1'b1;
        wait_nrd(1, 100, ok);
        check("susp_reach_data", ok, 1);
        a_diag = 1'b1;
        step();
        check("susp_wr", a_wr, 0);
        check("susp_rd", a_rd, 0);
        check("susp_busy", a_busy, 0);
        check("susp_tx", a_tx, 8'h2E);
        check("susp_chd", a_chd, 48'hABCDEF_123456);
        a_adc_rdy = 1'b0;
        step();
        a_adc_rdy = 1'b1;
        repeat (3) step();
        check("susp_edge_busy", a_busy, 0);
        check("susp_edge_ovr", a_ovr, 0);
        a_diag = 1'b0;
        repeat (3) step();
        check("susp_held_rdy_busy", a_busy, 0);
        check("susp_dv_count", a_dvn, 0);
        a_rxq.delete();

        // overrun: second edge during channel 1 byte 2
        a_adc_rdy = 1'b0;
        step();
        clear_stats();
        a_rxq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                  8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        a_adc_rdy = 1'b1;
        step();
        step();
        a_adc_rdy = 1'b0;
        wait_nrd(5, 200, ok);
        check("ovr_reach_byte", ok, 1);
        step();
        step();
        a_adc_rdy = 1'b1;
        step();
        check("ovr_flag", a_ovr, 1);
        check("ovr_busy", a_busy, 1);
        check("ovr_chd_kept", a_chd, 48'hABCDEF_123456);
        wait_valid(1'b0, 200, lat);
        check("ovr_restart_latency", lat, 42);
        check("ovr_new_chd", a_chd, 48'h040506_010203);
        check("ovr_addr_cnt", a_alog.size(), 4);
        if (a_alog.size() == 4) begin
            check("ovr_restart_addr", a_alog[2], 8'h2E);
        end
        step();
        check("ovr_dv_count", a_dvn, 1);
        check("ovr_sticky", a_ovr, 1);

        // reset mid-frame
        a_adc_rdy = 1'b0;
        step();
        clear_stats();
        a_rxq = '{8'h5A, 8'hA5, 8'h3C};
        a_adc_rdy = 1'b1;
        wait_nrd(2, 100, ok);
        check("rstm_reach_data", ok, 1);
        rst = 1'b1;
        #2;
        check("rstm_wr", a_wr, 0);
        check("rstm_rd", a_rd, 0);
        check("rstm_busy", a_busy, 0);
        check("rstm_ovr", a_ovr, 0);
        check("rstm_chd", a_chd, 0);
        check("rstm_tx", a_tx, 8'h2E);
        check("rstm_dv", a_dv, 0);
        step();
        rst = 1'b0;
        a_done = 1'b0;
        step();

        check("never_both_a", a_both, 0);
        check("never_both_b", b_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_afe_adc_multi_reader
